// File: rtl/lc3_core_if.sv
// Word-addressed memory bus between the LC-3 core and its memory.
// A transfer completes on a rising edge with mem_req and mem_ready both high.
interface lc3_core_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lc3_core.sv
// Multi-cycle LC-3 core: fetch/decode/memory FSM with registered bus outputs.
// Operate and control instructions complete in DECODE; loads and stores add MEM/MEM_IND.
module lc3_core #(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clk,
    input  logic        reset,
    lc3_core_if.master  mem,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [2:0]  nzp,
    output logic        retired,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEM, S_MEM_IND, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
        OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_t;

    state_t            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [2:0]        nzp_q, nzp_d;
    logic [15:0]       regs_q [8];
    logic [15:0]       regs_d [8];
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              retired_q, retired_d;

    opcode_t     op;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] rs1_val, rs2_val, sr_val;
    logic [15:0] alu_b, wb_val, ea;
    logic        accept, done;

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])           return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                 return 3'b001;
    endfunction

    assign op      = opcode_t'(ir_q[15:12]);
    assign dr      = ir_q[11:9];
    assign sr1     = ir_q[8:6];
    assign sr2     = ir_q[2:0];
    assign sext5   = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sext6   = {{10{ir_q[5]}}, ir_q[5:0]};
    assign sext9   = {{7{ir_q[8]}}, ir_q[8:0]};
    assign sext11  = {{5{ir_q[10]}}, ir_q[10:0]};
    assign rs1_val = regs_q[sr1];
    assign rs2_val = regs_q[sr2];
    assign sr_val  = regs_q[dr];
    assign alu_b   = ir_q[5] ? sext5 : rs2_val;
    assign accept  = req_q & mem.mem_ready;

    always_comb begin
        // NOTE: every _d starts as its _q, so no path through the case below can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        nzp_d     = nzp_q;
        regs_d    = regs_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        retired_d = 1'b0;
        done      = 1'b0;
        wb_val    = 16'h0000;
        ea        = 16'h0000;

        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q[ADDR_W-1:0];
                end else if (accept) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        if (op == OP_ADD)      wb_val = rs1_val + alu_b;
                        else if (op == OP_AND) wb_val = rs1_val & alu_b;
                        else                   wb_val = ~rs1_val;
                        regs_d[dr] = wb_val;
                        nzp_d      = cc_of(wb_val);
                        done       = 1'b1;
                    end
                    OP_BR: begin
                        if ((ir_q[11:9] & nzp_q) != 3'b000) pc_d = pc_q + sext9;
                        done = 1'b1;
                    end
                    OP_JMP: begin
                        pc_d = rs1_val;
                        done = 1'b1;
                    end
                    OP_JSR: begin
                        // BaseR is read from regs_q, so JSRR R7 jumps to the old R7.
                        regs_d[7] = pc_q;
                        pc_d      = ir_q[11] ? pc_q + sext11 : rs1_val;
                        done      = 1'b1;
                    end
                    OP_LEA: begin
                        regs_d[dr] = pc_q + sext9;
                        done       = 1'b1;
                    end
                    OP_LD, OP_ST, OP_LDI, OP_STI, OP_LDR, OP_STR: begin
                        ea      = (op == OP_LDR || op == OP_STR) ? rs1_val + sext6 : pc_q + sext9;
                        req_d   = 1'b1;
                        we_d    = (op == OP_ST || op == OP_STR);
                        addr_d  = ea[ADDR_W-1:0];
                        wdata_d = sr_val;
                        state_d = S_MEM;
                    end
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                if (accept) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    case (op)
                        OP_LD, OP_LDR: begin
                            regs_d[dr] = mem.mem_rdata;
                            nzp_d      = cc_of(mem.mem_rdata);
                            done       = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            req_d   = 1'b1;
                            we_d    = (op == OP_STI);
                            addr_d  = mem.mem_rdata[ADDR_W-1:0];
                            state_d = S_MEM_IND;
                        end
                        default: done = 1'b1;
                    endcase
                end
            end

            S_MEM_IND: begin
                if (accept) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (op == OP_LDI) begin
                        regs_d[dr] = mem.mem_rdata;
                        nzp_d      = cc_of(mem.mem_rdata);
                    end
                    done = 1'b1;
                end
            end

            default: req_d = 1'b0;
        endcase

        // Completion immediately issues the next fetch so the bus stays registered.
        if (done) begin
            state_d   = S_FETCH;
            req_d     = 1'b1;
            we_d      = 1'b0;
            addr_d    = pc_d[ADDR_W-1:0];
            retired_d = 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge _d values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            nzp_q     <= 3'b010;
            // NOTE: the register file is reset because software may read R0-R7 before
            // writing them; a large RAM would normally be left without a reset.
            regs_q    <= '{default: 16'h0000};
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            nzp_q     <= nzp_d;
            regs_q    <= regs_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            retired_q <= retired_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign dbg_data = regs_q[dbg_sel];
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign nzp      = nzp_q;
    assign retired  = retired_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_lc3_core.sv
// Scoreboarded bench for lc3_core: expected bus transfers are queued with each
// program and checked as the core issues them; architectural state is checked at retire.
module tb_lc3_core;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_data, pc, ir;
    logic [2:0]  nzp;
    logic        retired, halted;

    lc3_core_if #(.ADDR_W(16)) bus ();

    lc3_core #(.ADDR_W(16), .RESET_PC(16'h3000)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .pc       (pc),
        .ir       (ir),
        .nzp      (nzp),
        .retired  (retired),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];

    xfer_t exp_q[$];
    int vectors = 0, miscompares = 0;
    int cycle = 0;
    int retire_cnt = 0, retire_base = 0;
    int xfer_cnt = 0, xfer_base = 0, xfer_at_retire = 0;
    int first_req_cyc = 0, last_retire_cyc = 0, last_gap = 0;
    int stall_used = 0, stall_cycles = 0;
    logic [15:0] stall_addr = 16'hFFFF;
    logic        seen_req = 1'b0, stalled = 1'b0;
    logic        hold_we;
    logic [15:0] hold_addr, hold_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Memory responder and scoreboard consumer, evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            bus.mem_ready = 1'b0;
            seen_req      = 1'b0;
            stalled       = 1'b0;
            stall_used    = 0;
        end else begin
            if (bus.mem_req && bus.mem_addr == stall_addr && stall_used < stall_cycles) begin
                bus.mem_ready = 1'b0;
                stall_used++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            if (retired) begin
                retire_cnt++;
                last_gap        = cycle - last_retire_cyc;
                last_retire_cyc = cycle;
                xfer_at_retire  = xfer_cnt;
            end
            if (bus.mem_req && !seen_req) begin
                seen_req      = 1'b1;
                first_req_cyc = cycle;
            end
            if (bus.mem_req && stalled) begin
                check("stall_addr_stable", bus.mem_addr, hold_addr);
                check("stall_we_stable", bus.mem_we, hold_we);
                check("stall_wdata_stable", bus.mem_wdata, hold_data);
            end
            stalled = bus.mem_req && !bus.mem_ready;
            if (stalled) begin
                hold_addr = bus.mem_addr;
                hold_we   = bus.mem_we;
                hold_data = bus.mem_wdata;
            end
            if (bus.mem_req && bus.mem_ready) begin
                xfer_cnt++;
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    check("xfer_we", bus.mem_we, e.we);
                    check("xfer_addr", bus.mem_addr, e.addr);
                    if (e.we) check("xfer_wdata", bus.mem_wdata, e.data);
                end
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d;
    endtask

    task automatic expect_x(input logic we, input logic [15:0] a, input logic [15:0] d);
        xfer_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic begin_test();
        @(negedge clk);
        #1 reset = 1'b1;
        stall_cycles = 0;
        stall_addr   = 16'hFFFF;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        exp_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        retire_base = retire_cnt;
        xfer_base   = xfer_cnt;
        reset       = 1'b0;
    endtask

    task automatic wait_retire(input int n, input int budget);
        int k = 0;
        while ((retire_cnt - retire_base) < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check("retire_reached", (retire_cnt - retire_base) >= n, 1);
    endtask

    task automatic rd(input logic [2:0] i, output logic [15:0] v);
        @(negedge clk);
        dbg_sel = i;
        #1 v = dbg_data;
    endtask

    task automatic expect_halt(input logic [15:0] exp_pc);
        int k = 0, nreq = 0;
        while (!halted && k < 40) begin
            @(negedge clk); #1; k++;
        end
        check("halted", halted, 1);
        repeat (20) begin
            @(negedge clk); #1;
            if (bus.mem_req) nreq++;
        end
        check("halt_noreq", nreq, 0);
        check("halt_pc", pc, exp_pc);
        check("xfer_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] v;
        int k;

        // ADD R1,R1,#1 then TRAP; also covers reset values.
        begin_test();
        poke(16'h3000, 16'h1261); poke(16'h3001, 16'hF025);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3001, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 16'h3000);
        check("rst_ir", ir, 16'h0000);
        check("rst_nzp", nzp, 3'b010);
        check("rst_req", bus.mem_req, 0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        release_reset();
        wait_retire(1, 50);
        check("add_pc", pc, 16'h3001);
        check("add_nzp", nzp, 3'b001);
        check("add_cycles", last_retire_cyc - first_req_cyc, 2);
        expect_halt(16'h3002);
        check("add_retire_once", retire_cnt - retire_base, 1);
        rd(3'd1, v); check("add_r1", v, 16'h0001);

        // AND R2,R2,#0 ; BRz #2 (taken)
        begin_test();
        poke(16'h3000, 16'h54A0); poke(16'h3001, 16'h0402);
        poke(16'h3002, 16'hF025); poke(16'h3004, 16'hF025);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3001, 0); expect_x(0, 16'h3004, 0);
        release_reset();
        wait_retire(1, 50);
        check("and_nzp", nzp, 3'b010);
        wait_retire(2, 50);
        check("brz_pc", pc, 16'h3004);
        expect_halt(16'h3005);
        rd(3'd2, v); check("and_r2", v, 16'h0000);

        // AND R2,R2,#0 ; BRp #2 (not taken)
        begin_test();
        poke(16'h3000, 16'h54A0); poke(16'h3001, 16'h0202);
        poke(16'h3002, 16'hF025); poke(16'h3004, 16'hF025);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3001, 0); expect_x(0, 16'h3002, 0);
        release_reset();
        wait_retire(2, 50);
        check("brp_pc", pc, 16'h3002);
        check("brp_nzp", nzp, 3'b010);
        expect_halt(16'h3003);

        // LDI R3,#4 through x3005 -> x4000
        begin_test();
        poke(16'h3000, 16'hA604); poke(16'h3001, 16'hF025);
        poke(16'h3005, 16'h4000); poke(16'h4000, 16'h8001);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3005, 0);
        expect_x(0, 16'h4000, 0); expect_x(0, 16'h3001, 0);
        release_reset();
        wait_retire(1, 50);
        check("ldi_nzp", nzp, 3'b100);
        check("ldi_cycles", last_retire_cyc - first_req_cyc, 4);
        check("ldi_xfers", xfer_at_retire - xfer_base, 3);
        expect_halt(16'h3002);
        rd(3'd3, v); check("ldi_r3", v, 16'h8001);

        // LD R6 ; LD R1 ; STR R1,R6,#-1 with 3 wait cycles on the store
        begin_test();
        poke(16'h3000, 16'h2C03); poke(16'h3001, 16'h2203);
        poke(16'h3002, 16'h73BF); poke(16'h3003, 16'hF025);
        poke(16'h3004, 16'h5000); poke(16'h3005, 16'hBEEF);
        stall_addr = 16'h4FFF; stall_cycles = 3;
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3004, 0);
        expect_x(0, 16'h3001, 0); expect_x(0, 16'h3005, 0);
        expect_x(0, 16'h3002, 0); expect_x(1, 16'h4FFF, 16'hBEEF);
        expect_x(0, 16'h3003, 0);
        release_reset();
        wait_retire(2, 50);
        check("ld_gap", last_gap, 3);
        check("ld_nzp", nzp, 3'b100);
        wait_retire(3, 50);
        check("str_gap", last_gap, 6);
        check("str_nzp", nzp, 3'b100);
        check("str_waits", stall_used, 3);
        expect_halt(16'h3004);
        rd(3'd6, v); check("ld_r6", v, 16'h5000);
        rd(3'd1, v); check("ld_r1", v, 16'hBEEF);

        // LD R7 ; JSRR R7
        begin_test();
        poke(16'h3000, 16'h2E02); poke(16'h3001, 16'h41C0);
        poke(16'h3003, 16'h6000); poke(16'h6000, 16'hF025);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3003, 0);
        expect_x(0, 16'h3001, 0); expect_x(0, 16'h6000, 0);
        release_reset();
        wait_retire(2, 50);
        check("jsrr_pc", pc, 16'h6000);
        check("jsrr_nzp", nzp, 3'b001);
        expect_halt(16'h6001);
        rd(3'd7, v); check("jsrr_r7", v, 16'h3002);

        // Reset while an LD request is held waiting
        begin_test();
        poke(16'h3000, 16'h1261); poke(16'h3001, 16'h2404);
        poke(16'h3002, 16'hF025); poke(16'h3006, 16'h1234);
        stall_addr = 16'h3006; stall_cycles = 1000;
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3001, 0); expect_x(0, 16'h3006, 0);
        release_reset();
        wait_retire(1, 50);
        k = 0;
        while (!(bus.mem_req && bus.mem_addr == 16'h3006) && k < 50) begin
            @(negedge clk); #1; k++;
        end
        check("ld_req_seen", bus.mem_req, 1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        check("abandon_pending", exp_q.size(), 1);
        @(posedge clk);
        #1;
        check("rst_req_drop", bus.mem_req, 0);
        exp_q.delete();
        stall_addr = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            check($sformatf("rst_r%0d", i), v, 16'h0000);
        end
        check("rst_pc2", pc, 16'h3000);
        expect_x(0, 16'h3000, 0); expect_x(0, 16'h3001, 0);
        expect_x(0, 16'h3006, 0); expect_x(0, 16'h3002, 0);
        release_reset();
        wait_retire(2, 60);
        check("rerun_nzp", nzp, 3'b001);
        expect_halt(16'h3003);
        rd(3'd1, v); check("rerun_r1", v, 16'h0001);
        rd(3'd2, v); check("rerun_r2", v, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
